// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared widths, FSM state encoding and counter helper for the
//            data-memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FREEZE = 2'd2
    } arb_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : (v + 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Debug/loader access channel: request, grant and read return.
// Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rvalid;

    modport master (
        output req, we, addr, wr_data,
        input  gnt, rd_data, rvalid
    );

    modport slave (
        input  req, we, addr, wr_data,
        output gnt, rd_data, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/dmem_mux.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mux
// Purpose  : Combinational memory port select; the core always wins.
// Revision : 1.0  initial release
// ============================================================================
module dmem_mux
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              core_rd_enb_i,
    input  wire logic              core_wr_enb_i,
    input  wire logic [ADDR_W-1:0] core_addr_i,
    input  wire logic [DATA_W-1:0] core_wr_data_i,
    input  wire logic              dbg_req_i,
    input  wire logic              dbg_we_i,
    input  wire logic [ADDR_W-1:0] dbg_addr_i,
    input  wire logic [DATA_W-1:0] dbg_wr_data_i,
    output logic                   dbg_gnt_o,
    output logic                   mem_rd_enb_o,
    output logic                   mem_wr_enb_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wr_data_o
);

    logic w_core_busy;

    assign w_core_busy = core_rd_enb_i | core_wr_enb_i;

    // Core signals pass straight through by default so the core path has
    // no added logic depth beyond this one select.
    always_comb begin
        mem_rd_enb_o  = core_rd_enb_i;
        mem_wr_enb_o  = core_wr_enb_i;
        mem_addr_o    = core_addr_i;
        mem_wr_data_o = core_wr_data_i;
        dbg_gnt_o     = 1'b0;
        if (!w_core_busy && dbg_req_i) begin
            mem_rd_enb_o  = ~dbg_we_i;
            mem_wr_enb_o  = dbg_we_i;
            mem_addr_o    = dbg_addr_i;
            mem_wr_data_o = dbg_wr_data_i;
            dbg_gnt_o     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the data memory between core and debug port, with a
//            starvation counter that freezes instruction fetch.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              core_rd_enb_i,
    input  wire logic              core_wr_enb_i,
    input  wire logic [ADDR_W-1:0] core_addr_i,
    input  wire logic [DATA_W-1:0] core_wr_data_i,
    output logic [DATA_W-1:0]      core_rd_data_o,
    dmem_arbiter_if.slave          dbg,
    input  wire logic              fetch_enable_i,
    output logic                   fetch_enable_o,
    output logic                   mem_rd_enb_o,
    output logic                   mem_wr_enb_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wr_data_o,
    input  wire logic [DATA_W-1:0] mem_rd_data_i
);

    localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              w_gnt;
    logic              w_waiting;
    logic              w_freeze;

    dmem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .core_rd_enb_i  (core_rd_enb_i),
        .core_wr_enb_i  (core_wr_enb_i),
        .core_addr_i    (core_addr_i),
        .core_wr_data_i (core_wr_data_i),
        .dbg_req_i      (dbg.req),
        .dbg_we_i       (dbg.we),
        .dbg_addr_i     (dbg.addr),
        .dbg_wr_data_i  (dbg.wr_data),
        .dbg_gnt_o      (w_gnt),
        .mem_rd_enb_o   (mem_rd_enb_o),
        .mem_wr_enb_o   (mem_wr_enb_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o)
    );

    assign w_waiting      = dbg.req & ~w_gnt;
    assign w_freeze       = (state_q == ST_FREEZE);
    assign fetch_enable_o = fetch_enable_i & ~w_freeze;
    assign core_rd_data_o = mem_rd_data_i;
    assign dbg.gnt        = w_gnt;
    assign dbg.rd_data    = rdata_q;
    assign dbg.rvalid     = rvalid_q;

    // Freeze is taken on the counter's next value, so the MAX_WAIT-th
    // ungranted cycle moves straight into FREEZE even if the core is busy.
    // Checking from IDLE as well keeps MAX_WAIT = 1 meaningful.
    always_comb begin
        cnt_d   = w_waiting ? sat_inc(cnt_q, C_MAX_WAIT) : '0;
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (w_waiting)
                    state_d = (cnt_d == C_MAX_WAIT) ? ST_FREEZE : ST_WAIT;
                else
                    state_d = ST_IDLE;
            end
            ST_FREEZE: begin
                if (w_gnt || !dbg.req)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory read data arrives the cycle after the grant; capture it then
    // and present it with a single-cycle valid.
    always_comb begin
        rd_pend_d = w_gnt & ~dbg.we;
        rvalid_d  = rd_pend_q;
        rdata_d   = rd_pend_q ? mem_rd_data_i : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboarded directed bench for dmem_arbiter (MAX_WAIT = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_gnt_t;

    logic       clk;
    logic       rst;
    logic       core_rd_enb_i, core_wr_enb_i;
    logic [7:0] core_addr_i, core_wr_data_i, core_rd_data_o;
    logic       fetch_enable_i, fetch_enable_o;
    logic       mem_rd_enb_o, mem_wr_enb_o;
    logic [7:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;

    logic [7:0] mem [256];

    exp_gnt_t   gq[$];
    logic [7:0] rq[$];

    int n_total;
    int n_pass;
    int n_rvalid;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) dbg ();

    dmem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .core_rd_enb_i  (core_rd_enb_i),
        .core_wr_enb_i  (core_wr_enb_i),
        .core_addr_i    (core_addr_i),
        .core_wr_data_i (core_wr_data_i),
        .core_rd_data_o (core_rd_data_o),
        .dbg            (dbg),
        .fetch_enable_i (fetch_enable_i),
        .fetch_enable_o (fetch_enable_o),
        .mem_rd_enb_o   (mem_rd_enb_o),
        .mem_wr_enb_o   (mem_wr_enb_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_rd_data_i  (mem_rd_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: read data valid the cycle after enable.
    always @(posedge clk) begin
        if (mem_wr_enb_o) mem[mem_addr_o] <= mem_wr_data_o;
        if (mem_rd_enb_o) mem_rd_data_i <= mem[mem_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares whenever the DUT grants or returns data.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_rd_enb_i && core_wr_enb_i)
                chk("core_rd_wr_illegal", 1, 0);
            if (dbg.gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 1, 0);
                end else begin
                    exp_gnt_t e;
                    e = gq.pop_front();
                    chk("gnt_addr", {24'd0, mem_addr_o}, {24'd0, e.addr});
                    chk("gnt_wr_enb", {31'd0, mem_wr_enb_o}, {31'd0, e.we});
                    chk("gnt_rd_enb", {31'd0, mem_rd_enb_o}, {31'd0, ~e.we});
                    if (e.we) chk("gnt_wr_data", {24'd0, mem_wr_data_o}, {24'd0, e.data});
                end
            end
            if (dbg.rvalid) begin
                n_rvalid++;
                if (rq.size() == 0) chk("unexpected_rvalid", 1, 0);
                else chk("rd_data", {24'd0, dbg.rd_data}, {24'd0, rq.pop_front()});
            end
        end
    end

    task automatic dbg_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                              input int budget, output int waited);
        bit got;
        dbg.req = 1'b1; dbg.we = we; dbg.addr = a; dbg.wr_data = d;
        gq.push_back('{we: we, addr: a, data: d});
        got = 0;
        waited = 0;
        while (!got && waited < budget) begin
            @(negedge clk);
            if (dbg.gnt) got = 1;
            else waited++;
        end
        if (!got) chk("gnt_timeout", 0, 1);
        tick();
        dbg.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int r0;
        n_total = 0; n_pass = 0; n_rvalid = 0;
        rst = 1'b1;
        core_rd_enb_i = 0; core_wr_enb_i = 0; core_addr_i = 0; core_wr_data_i = 0;
        fetch_enable_i = 1'b1;
        dbg.req = 0; dbg.we = 0; dbg.addr = 0; dbg.wr_data = 0;
        repeat (2) tick();

        @(negedge clk);
        chk("rst_fetch_en", {31'd0, fetch_enable_o}, 1);
        chk("rst_rvalid", {31'd0, dbg.rvalid}, 0);
        chk("rst_rd_data", {24'd0, dbg.rd_data}, 0);
        chk("rst_state", 32'(dut.state_q), 0);
        tick();
        rst = 1'b0;

        fetch_enable_i = 1'b0;
        @(negedge clk);
        chk("fetch_en_gated_in", {31'd0, fetch_enable_o}, 0);
        tick();
        fetch_enable_i = 1'b1;

        core_addr_i = 8'h99; core_wr_data_i = 8'h12;
        @(negedge clk);
        chk("idle_mem_addr", {24'd0, mem_addr_o}, 32'h99);
        chk("idle_mem_wdata", {24'd0, mem_wr_data_o}, 32'h12);
        chk("idle_enables", {30'd0, mem_rd_enb_o, mem_wr_enb_o}, 0);
        tick();

        dbg_access(1'b1, 8'h3C, 8'hA5, 8, w);
        chk("idle_wr_latency", w, 0);

        // Readback with exact rvalid timing: grant, pending, then data.
        dbg.req = 1; dbg.we = 0; dbg.addr = 8'h3C;
        gq.push_back('{we: 1'b0, addr: 8'h3C, data: 8'h00});
        rq.push_back(8'hA5);
        @(negedge clk);
        chk("rd_gnt", {31'd0, dbg.gnt}, 1);
        tick();
        dbg.req = 0;
        @(negedge clk);
        chk("rd_rvalid_g1", {31'd0, dbg.rvalid}, 0);
        tick();
        @(negedge clk);
        chk("rd_rvalid_g2", {31'd0, dbg.rvalid}, 1);
        chk("rd_data_g2", {24'd0, dbg.rd_data}, 32'hA5);
        tick();
        @(negedge clk);
        chk("rd_rvalid_g3", {31'd0, dbg.rvalid}, 0);
        tick();

        dbg_access(1'b1, 8'h10, 8'h4A, 8, w);
        dbg_access(1'b1, 8'h40, 8'h11, 8, w);
        dbg_access(1'b1, 8'h41, 8'h22, 8, w);

        r0 = n_rvalid;
        dbg.req = 1; dbg.we = 0; dbg.addr = 8'h40;
        gq.push_back('{we: 1'b0, addr: 8'h40, data: 8'h00}); rq.push_back(8'h11);
        tick();
        dbg.addr = 8'h41;
        gq.push_back('{we: 1'b0, addr: 8'h41, data: 8'h00}); rq.push_back(8'h22);
        tick();
        dbg.req = 0;
        repeat (4) tick();
        chk("b2b_rvalid_count", n_rvalid - r0, 2);

        // Core priority over a pending debug read.
        core_rd_enb_i = 1; core_addr_i = 8'h10;
        dbg.req = 1; dbg.we = 0; dbg.addr = 8'h3C;
        gq.push_back('{we: 1'b0, addr: 8'h3C, data: 8'h00}); rq.push_back(8'hA5);
        @(negedge clk);
        chk("prio_mem_addr", {24'd0, mem_addr_o}, 32'h10);
        chk("prio_no_gnt", {31'd0, dbg.gnt}, 0);
        chk("prio_core_rd", {31'd0, mem_rd_enb_o}, 1);
        tick();
        core_rd_enb_i = 0;
        @(negedge clk);
        chk("prio_dbg_gnt", {31'd0, dbg.gnt}, 1);
        chk("core_rd_data", {24'd0, core_rd_data_o}, 32'h4A);
        tick();
        dbg.req = 0;
        repeat (3) tick();

        // Starvation with MAX_WAIT = 4.
        core_rd_enb_i = 1; core_addr_i = 8'h20;
        dbg.req = 1; dbg.we = 1; dbg.addr = 8'h50; dbg.wr_data = 8'h77;
        gq.push_back('{we: 1'b1, addr: 8'h50, data: 8'h77});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("starve_fetch_pre", {31'd0, fetch_enable_o}, 1);
            chk("starve_no_gnt", {31'd0, dbg.gnt}, 0);
            tick();
            core_addr_i = core_addr_i + 8'd1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("starve_frozen", {31'd0, fetch_enable_o}, 0);
            tick();
        end
        core_rd_enb_i = 0;
        @(negedge clk);
        chk("freeze_gnt", {31'd0, dbg.gnt}, 1);
        chk("freeze_holds_on_gnt", {31'd0, fetch_enable_o}, 0);
        tick();
        dbg.req = 0;
        @(negedge clk);
        chk("freeze_released", {31'd0, fetch_enable_o}, 1);
        tick();

        // Withdrawal while waiting clears the counter.
        core_rd_enb_i = 1;
        dbg.req = 1; dbg.we = 1; dbg.addr = 8'h60; dbg.wr_data = 8'h33;
        repeat (2) tick();
        dbg.req = 0;
        tick();
        @(negedge clk);
        chk("withdraw_state", 32'(dut.state_q), 0);
        chk("withdraw_cnt", {24'd0, dut.cnt_q}, 0);
        chk("withdraw_fetch", {31'd0, fetch_enable_o}, 1);
        tick();
        dbg.req = 1;
        gq.push_back('{we: 1'b1, addr: 8'h60, data: 8'h33});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rewait_no_freeze", {31'd0, fetch_enable_o}, 1);
            tick();
        end
        core_rd_enb_i = 0;
        @(negedge clk);
        chk("rewait_gnt", {31'd0, dbg.gnt}, 1);
        tick();
        dbg.req = 0;
        tick();

        // Reset in the middle of FREEZE drops the pending request.
        core_rd_enb_i = 1;
        dbg.req = 1; dbg.we = 0; dbg.addr = 8'h3C;
        repeat (6) tick();
        @(negedge clk);
        chk("pre_rst_frozen", {31'd0, fetch_enable_o}, 0);
        tick();
        rst = 1;
        @(negedge clk);
        chk("midfreeze_rst_fetch", {31'd0, fetch_enable_o}, 1);
        chk("midfreeze_rst_rvalid", {31'd0, dbg.rvalid}, 0);
        chk("midfreeze_rst_state", 32'(dut.state_q), 0);
        tick();
        dbg.req = 0; core_rd_enb_i = 0;
        rst = 0;
        repeat (3) tick();

        chk("gnt_queue_empty", gq.size(), 0);
        chk("rd_queue_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
